// File: rtl/counter_updown_mod_if.sv
// Control/status bundle for counter_updown_mod: the controller drives the
// strobes and step, the counter returns its registered count and event flags.
interface counter_updown_mod_if #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
);
   logic              clr;
   logic              load;
   logic [WIDTH-1:0]  load_val;
   logic              en;
   logic              up;
   logic [STEP_W-1:0] step;
   logic [WIDTH-1:0]  count;
   logic              wrap;
   logic              ovf;
   logic              at_max;
   logic              at_zero;

   modport master (
      output clr, load, load_val, en, up, step,
      input  count, wrap, ovf, at_max, at_zero
   );

   modport slave (
      input  clr, load, load_val, en, up, step,
      output count, wrap, ovf, at_max, at_zero
   );
endinterface

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with variable step, parallel load,
// synchronous clear, wrap or saturate overrun handling and a sticky overflow flag.
module counter_updown_mod #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
   parameter int               STEP_W   = 4,
   parameter bit               SATURATE = 1'b0
) (
   input logic                 clk,
   input logic                 reset,
   counter_updown_mod_if.slave bus
);

   // One extra bit so count+step and count+modulus never overflow.
   localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX_VAL};
   localparam logic [WIDTH:0] MOD_EXT = MAX_EXT + {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_r;
   logic             wrap_r;
   logic             ovf_r;

   logic [WIDTH:0]   step_ext_s;
   logic [WIDTH:0]   eff_step_s;
   logic [WIDTH:0]   cnt_ext_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   sum_wrap_s;
   logic [WIDTH:0]   dif_s;
   logic [WIDTH:0]   dif_wrap_s;
   logic             over_up_s;
   logic             under_dn_s;
   logic [WIDTH-1:0] load_clamp_s;
   logic [WIDTH-1:0] next_count_s;
   logic             next_wrap_s;
   logic             next_ovf_s;

   // Next-state arithmetic and clr > load > en priority selection
   always_comb begin
      step_ext_s   = {{(WIDTH + 1 - STEP_W){1'b0}}, bus.step};
      eff_step_s   = (step_ext_s > MAX_EXT) ? MAX_EXT : step_ext_s;
      cnt_ext_s    = {1'b0, count_r};
      sum_s        = cnt_ext_s + eff_step_s;
      sum_wrap_s   = sum_s - MOD_EXT;
      dif_s        = cnt_ext_s - eff_step_s;
      dif_wrap_s   = cnt_ext_s + MOD_EXT - eff_step_s;
      over_up_s    = (sum_s > MAX_EXT);
      under_dn_s   = (cnt_ext_s < eff_step_s);
      load_clamp_s = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;

      next_count_s = count_r;
      next_wrap_s  = 1'b0;
      next_ovf_s   = ovf_r;

      if (bus.clr) begin
         next_count_s = {WIDTH{1'b0}};
         next_ovf_s   = 1'b0;
      end else if (bus.load) begin
         next_count_s = load_clamp_s;
      end else if (bus.en) begin
         if (bus.up) begin
            if (over_up_s) begin
               next_count_s = SATURATE ? MAX_VAL : sum_wrap_s[WIDTH-1:0];
               next_wrap_s  = 1'b1;
               next_ovf_s   = 1'b1;
            end else begin
               next_count_s = sum_s[WIDTH-1:0];
            end
         end else begin
            if (under_dn_s) begin
               next_count_s = SATURATE ? {WIDTH{1'b0}} : dif_wrap_s[WIDTH-1:0];
               next_wrap_s  = 1'b1;
               next_ovf_s   = 1'b1;
            end else begin
               next_count_s = dif_s[WIDTH-1:0];
            end
         end
      end else begin
         next_count_s = count_r;
      end
   end

   // Count, event pulse and sticky flag registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r <= {WIDTH{1'b0}};
         wrap_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         count_r <= next_count_s;
         wrap_r  <= next_wrap_s;
         ovf_r   <= next_ovf_s;
      end
   end

   assign bus.count   = count_r;
   assign bus.wrap    = wrap_r;
   assign bus.ovf     = ovf_r;
   assign bus.at_max  = (count_r == MAX_VAL);
   assign bus.at_zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_counter_updown_mod.sv
// Three counter configurations share one stimulus stream and are checked every
// cycle against an arithmetic reference model, plus directed literal checks.
module tb_counter_updown_mod;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'd0;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic [3:0] step = 4'd0;

   int checks = 0;
   int errors = 0;

   // Instance 0: 0..255 wrap; 1: 0..9 wrap; 2: 0..9 saturate.
   int p_max [3] = '{255, 9, 9};
   int p_sat [3] = '{0, 0, 1};

   int m_count [3] = '{0, 0, 0};
   bit m_wrap  [3] = '{1'b0, 1'b0, 1'b0};
   bit m_ovf   [3] = '{1'b0, 1'b0, 1'b0};

   logic [7:0] dcount [3];
   logic       dwrap [3];
   logic       dovf [3];
   logic       dmax [3];
   logic       dzero [3];

   always #5 clk = ~clk;

   counter_updown_mod_if #(.WIDTH(8), .STEP_W(4)) if0 ();
   counter_updown_mod_if #(.WIDTH(8), .STEP_W(4)) if1 ();
   counter_updown_mod_if #(.WIDTH(8), .STEP_W(4)) if2 ();

   assign {if0.clr, if1.clr, if2.clr}                = {3{clr}};
   assign {if0.load, if1.load, if2.load}             = {3{load}};
   assign {if0.load_val, if1.load_val, if2.load_val} = {3{load_val}};
   assign {if0.en, if1.en, if2.en}                   = {3{en}};
   assign {if0.up, if1.up, if2.up}                   = {3{up}};
   assign {if0.step, if1.step, if2.step}             = {3{step}};

   assign dcount[0] = if0.count;  assign dwrap[0] = if0.wrap;  assign dovf[0] = if0.ovf;
   assign dcount[1] = if1.count;  assign dwrap[1] = if1.wrap;  assign dovf[1] = if1.ovf;
   assign dcount[2] = if2.count;  assign dwrap[2] = if2.wrap;  assign dovf[2] = if2.ovf;
   assign dmax[0] = if0.at_max;   assign dzero[0] = if0.at_zero;
   assign dmax[1] = if1.at_max;   assign dzero[1] = if1.at_zero;
   assign dmax[2] = if2.at_max;   assign dzero[2] = if2.at_zero;

   counter_updown_mod #(.WIDTH(8), .MAX_VAL(8'd255), .STEP_W(4), .SATURATE(1'b0))
      u0 (.clk(clk), .reset(reset), .bus(if0));
   counter_updown_mod #(.WIDTH(8), .MAX_VAL(8'd9), .STEP_W(4), .SATURATE(1'b0))
      u1 (.clk(clk), .reset(reset), .bus(if1));
   counter_updown_mod #(.WIDTH(8), .MAX_VAL(8'd9), .STEP_W(4), .SATURATE(1'b1))
      u2 (.clk(clk), .reset(reset), .bus(if2));

   function automatic bit overrun(int maxv, int c, bit up_i, int stp);
      int s;
      s = (stp > maxv) ? maxv : stp;
      return up_i ? (c + s > maxv) : (c < s);
   endfunction

   function automatic int next_count(int maxv, int sat, int c, bit clr_i, bit load_i,
                                     int lv, bit en_i, bit up_i, int stp);
      int s;
      s = (stp > maxv) ? maxv : stp;
      if (clr_i) return 0;
      if (load_i) return (lv > maxv) ? maxv : lv;
      if (!en_i) return c;
      if (up_i) begin
         if (c + s <= maxv) return c + s;
         return sat ? maxv : c + s - (maxv + 1);
      end
      if (c >= s) return c - s;
      return sat ? 0 : c + (maxv + 1) - s;
   endfunction

   // Reference model advances on the same edges as the counters
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 3; i++) begin
            m_count[i] <= 0;
            m_wrap[i]  <= 1'b0;
            m_ovf[i]   <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            m_count[i] <= next_count(p_max[i], p_sat[i], m_count[i], clr, load,
                                     int'(load_val), en, up, int'(step));
            m_wrap[i]  <= !clr && !load && en && overrun(p_max[i], m_count[i], up, int'(step));
            m_ovf[i]   <= clr ? 1'b0 :
                          ((!load && en && overrun(p_max[i], m_count[i], up, int'(step))) ? 1'b1 : m_ovf[i]);
         end
      end
   end

   task automatic chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every instance against the model
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("count%0d", i), dcount[i], m_count[i]);
         chk($sformatf("wrap%0d", i), dwrap[i], m_wrap[i]);
         chk($sformatf("ovf%0d", i), dovf[i], m_ovf[i]);
         chk($sformatf("at_max%0d", i), dmax[i], (m_count[i] == p_max[i]) ? 1 : 0);
         chk($sformatf("at_zero%0d", i), dzero[i], (m_count[i] == 0) ? 1 : 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(string name, int i, int c, int w, int o);
      chk({name, "_count"}, dcount[i], c);
      chk({name, "_model"}, m_count[i], c);
      chk({name, "_wrap"}, dwrap[i], w);
      chk({name, "_ovf"}, dovf[i], o);
   endtask

   initial begin
      #1 reset = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) lit($sformatf("reset%0d", i), i, 0, 0, 0);
      chk("reset_at_zero", dzero[0], 1);
      @(negedge clk);
      reset = 1'b1;

      en = 1'b1; up = 1'b1; step = 4'd1;
      repeat (255) tick();
      lit("full_255", 0, 255, 0, 0);
      tick();
      lit("full_wrap", 0, 0, 1, 1);
      tick();
      lit("full_after", 0, 1, 0, 1);

      clr = 1'b1; en = 1'b0;
      tick();
      clr = 1'b0; en = 1'b1; step = 4'd3;
      tick(); lit("dec_3", 1, 3, 0, 0);
      tick(); lit("dec_6", 1, 6, 0, 0);
      tick(); lit("dec_9", 1, 9, 0, 0);
      chk("dec_at_max", dmax[1], 1);
      tick(); lit("dec_2", 1, 2, 1, 1);
      tick(); lit("dec_5", 1, 5, 0, 1);

      en = 1'b0; load = 1'b1; load_val = 8'd1;
      tick(); lit("dn_load", 1, 1, 0, 1);
      load = 1'b0; en = 1'b1; up = 1'b0; step = 4'd2;
      tick(); lit("dn_9", 1, 9, 1, 1);
      tick(); lit("dn_7", 1, 7, 0, 1);

      en = 1'b0; load = 1'b1; load_val = 8'd8;
      tick(); lit("sat_load", 2, 8, 0, 1);
      load = 1'b0; en = 1'b1; up = 1'b1; step = 4'd3;
      tick(); lit("sat_9a", 2, 9, 1, 1);
      tick(); lit("sat_9b", 2, 9, 1, 1);
      up = 1'b0; step = 4'd1;
      tick(); lit("sat_8", 2, 8, 0, 1);

      clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 8'd7;
      tick();
      for (int i = 0; i < 3; i++) lit($sformatf("prio%0d", i), i, 0, 0, 0);
      clr = 1'b0; load_val = 8'd200;
      tick();
      lit("clamp", 1, 9, 0, 0);
      chk("clamp_at_max", dmax[1], 1);
      lit("noclamp", 0, 200, 0, 0);

      clr = 1'b1; load = 1'b0; en = 1'b0;
      tick();
      clr = 1'b0; en = 1'b1; up = 1'b1; step = 4'd1;
      repeat (5) tick();
      lit("pre_rst", 0, 5, 0, 0);
      #2 reset = 1'b0;
      #1 lit("async_rst", 0, 0, 0, 0);
      tick();
      reset = 1'b1;
      tick(); lit("resume_1", 0, 1, 0, 0);
      tick(); lit("resume_2", 0, 2, 0, 0);

      for (int n = 0; n < 3000; n++) begin
         clr      = ($urandom % 32) == 0;
         load     = ($urandom % 16) == 0;
         load_val = 8'($urandom);
         en       = ($urandom % 4) != 0;
         up       = 1'($urandom);
         step     = 4'($urandom);
         if (($urandom % 200) == 0) begin
            #2 reset = 1'b0;
            #1 reset = 1'b1;
         end
         tick();
      end

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
